// File: rtl/huff_table_sched.sv
// huff_table_sched
// Sequencer and sole master of an external 256x8 Huffman symbol table.
// The sequence is: clear all 256 slots, build entries from the header
// parser, then serve decoder lookups against the finished table.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start, num_syms       start pulse; entry count latched on start (0 = 256)
//   bld_*                 build entry stream (length, path, char)
//   dec_*                 lookup request stream and 1-cycle-latency response
//   tbl_we/addr/wdata     table write port; tbl_addr also drives the read
//   tbl_rdata             table read data, combinational from tbl_addr
//   table_ready, err      build complete / build error status
//   dbg_state             current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Ready never depends on valid. A handshake in the same
// cycle as start is dropped; start always wins.
module huff_table_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  num_syms,
  input  logic        bld_valid,
  output logic        bld_ready,
  input  logic [3:0]  bld_length,
  input  logic [11:0] bld_path,
  input  logic [7:0]  bld_char,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [3:0]  dec_length,
  input  logic [11:0] dec_path,
  output logic        dec_rvalid,
  output logic [7:0]  dec_char,
  output logic        dec_hit,
  output logic        tbl_we,
  output logic [7:0]  tbl_addr,
  output logic [7:0]  tbl_wdata,
  input  logic [7:0]  tbl_rdata,
  output logic        table_ready,
  output logic        err,
  output logic [2:0]  dbg_state
);

  localparam int MAXLEN = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_BUILD = 3'd2,
    S_READY = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t         state_q;
  logic [7:0]     clr_q;
  logic [8:0]     cnt_q;
  logic [8:0]     nsyms_q;
  logic [255:0]   occ_q;
  logic           rvalid_q;
  logic [7:0]     char_q;
  logic           hit_q;

  // Returns {legal, slot}. Each longer code length gets a smaller slice of
  // the table packed above the previous one, so the sums stay within 8 bits.
  function automatic logic [8:0] hash_f(input logic [3:0] len,
                                        input logic [11:0] path);
    logic       ok;
    logic [7:0] a;
    ok = (len != 4'd0) && (int'(len) <= MAXLEN);
    a  = 8'd0;
    if (len >= 4'd1 && len <= 4'd7) begin
      a = {1'b0, path[6:0]};
    end else begin
      case (len)
        4'd8:    a = 8'd128 + {2'b00, path[8:3]};
        4'd9:    a = 8'd192 + {3'b000, path[9:5]};
        4'd10:   a = 8'd224 + {4'b0000, path[10:7]};
        4'd11:   a = 8'd240 + {5'b00000, path[11:9]};
        4'd12:   a = 8'd248 + {6'b000000, path[11:10]};
        default: a = 8'd0;
      endcase
    end
    return {ok, a};
  endfunction

  logic       bld_ok, dec_ok;
  logic [7:0] bld_h, dec_h;
  logic       bld_wr;

  assign {bld_ok, bld_h} = hash_f(bld_length, bld_path);
  assign {dec_ok, dec_h} = hash_f(dec_length, dec_path);

  // A build entry is written only when it lands in a free, legal slot.
  assign bld_wr = (state_q == S_BUILD) && bld_valid && !start &&
                  bld_ok && !occ_q[bld_h];

  assign bld_ready   = (state_q == S_BUILD);
  assign dec_ready   = (state_q == S_READY);
  assign table_ready = (state_q == S_READY);
  assign err         = (state_q == S_ERROR);
  assign dec_rvalid  = rvalid_q;
  assign dec_char    = char_q;
  assign dec_hit     = hit_q;
  assign dbg_state   = state_q;

  always_comb begin
    tbl_we    = 1'b0;
    tbl_addr  = 8'd0;
    tbl_wdata = 8'd0;
    case (state_q)
      S_CLEAR: begin
        tbl_we   = 1'b1;
        tbl_addr = clr_q;
      end
      S_BUILD: begin
        tbl_we    = bld_wr;
        tbl_addr  = bld_h;
        tbl_wdata = bld_char;
      end
      S_READY: tbl_addr = dec_h;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      clr_q    <= 8'd0;
      cnt_q    <= 9'd0;
      nsyms_q  <= 9'd0;
      occ_q    <= '0;
      rvalid_q <= 1'b0;
      char_q   <= 8'd0;
      hit_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (start) begin
        nsyms_q <= (num_syms == 9'd0) ? 9'd256 : num_syms;
        clr_q   <= 8'd0;
        cnt_q   <= 9'd0;
        state_q <= S_CLEAR;
      end else begin
        case (state_q)
          S_CLEAR: begin
            occ_q[clr_q] <= 1'b0;
            clr_q        <= clr_q + 8'd1;
            if (clr_q == 8'd255) begin
              cnt_q   <= 9'd0;
              state_q <= S_BUILD;
            end
          end
          S_BUILD: begin
            if (bld_valid) begin
              if (bld_wr) begin
                occ_q[bld_h] <= 1'b1;
                cnt_q        <= cnt_q + 9'd1;
                if (cnt_q + 9'd1 == nsyms_q) state_q <= S_READY;
              end else begin
                state_q <= S_ERROR;
              end
            end
          end
          S_READY: begin
            if (dec_valid) begin
              rvalid_q <= 1'b1;
              char_q   <= dec_ok ? tbl_rdata : 8'd0;
              hit_q    <= dec_ok && occ_q[dec_h];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
